// File: rtl/cpu_pkg.sv
// Shared types for the small RISC core: opcode and sequencer phase encodings.
package cpu_pkg;

  typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR,
    INST_FETCH,
    INST_LOAD,
    IDLE,
    OP_ADDR,
    OP_FETCH,
    ALU_OP,
    STORE
  } state_t;

  // Opcodes that fetch an operand and write the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Eight-phase control sequencer: one instruction per 8 clocks, strobes decoded
// combinationally from the current phase, the opcode and the ALU zero flag.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                mem_rd,
  output logic                load_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                load_ac,
  output logic                load_pc,
  output logic                mem_wr,
  output logic [2:0]          phase
);

  state_t  state_q, state_d;
  opcode_t op;
  logic    aluop;
  logic    halt_hold;

  assign op        = opcode_t'(opcode);
  assign aluop     = is_aluop(op);
  assign halt_hold = (state_q == OP_ADDR) && (op == HLT);

  // Next phase depends only on the current phase and the HLT condition.
  always_comb begin
    state_d = state_q;
    if (!halt_hold) begin
      state_d = state_t'(state_q + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    unique case (state_q)
      INST_ADDR: ;
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = (op == HLT);
        inc_pc = (op != HLT);
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (op == SKZ) && zero;
        load_pc = (op == JMP);
      end
      STORE: begin
        // JMP raises both; the counter gives load priority.
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (op == JMP);
        load_pc = (op == JMP);
        mem_wr  = (op == STO);
      end
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed instruction passes, reset and
// halt scenarios, then randomized opcodes against a phase-rule reference model.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;
  int mphase   = 0;

  cpu_sequencer #(.OPCODE_W(3)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rd  (mem_rd),
    .load_ir (load_ir),
    .halt    (halt),
    .inc_pc  (inc_pc),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .mem_wr  (mem_wr),
    .phase   (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}, from the phase rules.
  function automatic logic [6:0] model(int p, int op, logic z);
    logic alu;
    logic [6:0] e;
    alu  = (op >= 2) && (op <= 5);
    e[6] = (p >= 1 && p <= 3) || (p >= 5 && alu);
    e[5] = (p == 2) || (p == 3);
    e[4] = (p == 4) && (op == 0);
    e[3] = (p == 4 && op != 0) || (p == 6 && op == 1 && z) || (p == 7 && op == 7);
    e[2] = (p >= 6) && alu;
    e[1] = (p >= 6) && (op == 7);
    e[0] = (p == 7) && (op == 6);
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s phase=%0d op=%0d: observed=%0h expected=%0h",
             tag, mphase, opcode, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [6:0] e;
    e = rst_ ? model(mphase, int'(opcode), zero) : 7'd0;
    cmp({tag, "/phase"},   {5'd0, phase},   8'(mphase));
    cmp({tag, "/mem_rd"},  {7'd0, mem_rd},  {7'd0, e[6]});
    cmp({tag, "/load_ir"}, {7'd0, load_ir}, {7'd0, e[5]});
    cmp({tag, "/halt"},    {7'd0, halt},    {7'd0, e[4]});
    cmp({tag, "/inc_pc"},  {7'd0, inc_pc},  {7'd0, e[3]});
    cmp({tag, "/load_ac"}, {7'd0, load_ac}, {7'd0, e[2]});
    cmp({tag, "/load_pc"}, {7'd0, load_pc}, {7'd0, e[1]});
    cmp({tag, "/mem_wr"},  {7'd0, mem_wr},  {7'd0, e[0]});
    cmp({tag, "/rd_wr_excl"}, {7'd0, mem_rd & mem_wr}, 8'd0);
  endtask

  task automatic cyc(input string tag, input logic [2:0] op, input logic z);
    @(negedge clk);
    opcode = op;
    zero   = z;
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (rst_ && !(mphase == 4 && op == 3'd0)) mphase = (mphase + 1) % 8;
  endtask

  task automatic instr(input string tag, input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++) cyc(tag, op, z);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    mphase = 0;
    check_outputs({tag, "/assert"});
    @(negedge clk);
    #1;
    check_outputs({tag, "/held"});
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    check_outputs({tag, "/release"});
    @(posedge clk);
    mphase = 1;
  endtask

  initial begin
    rst_   = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    check_outputs("release");
    @(posedge clk);
    mphase = 1;
    for (int i = 1; i < 8; i++) cyc("warmup", 3'd2, 1'b0);

    instr("add", 3'd2, 1'b0);
    instr("skz_z1", 3'd1, 1'b1);
    instr("skz_z0", 3'd1, 1'b0);
    instr("jmp", 3'd7, 1'b1);
    instr("sto", 3'd6, 1'b0);
    instr("lda", 3'd5, 1'b1);

    // Reset in the middle of an ADD at phase 5, then confirm the wrap.
    while (mphase != 5) cyc("add_pre_rst", 3'd2, 1'b0);
    pulse_reset("rst_mid");
    for (int i = 1; i < 8; i++) cyc("after_rst", 3'd2, 1'b0);
    instr("wrap", 3'd3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(1, 7));
      for (int i = 0; i < 8; i++) cyc("rand", op, 1'($urandom_range(0, 1)));
    end

    // Halt: the sequencer must park in phase 4 until reset.
    for (int i = 0; i < 30; i++) cyc("hlt", 3'd0, 1'($urandom_range(0, 1)));
    pulse_reset("rst_hlt");
    for (int i = 1; i < 8; i++) cyc("post_hlt", 3'd4, 1'b0);
    instr("post_hlt2", 3'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
